mult_pipe: RTL and testbench
============================

# mult_pipe

Parametrised multiplier result pipeline for the exec stage. It carries a multiplier result and its side information (zero, overflow, register-write enable, destination register) through DEPTH registered stages, and delivers it to writeback. It adds per-stage valid tracking, a global stall and a flush, plus an occupancy count for issue control. An optional hazard-query port is compiled in by macro.

## Interface
- DEPTH, 4: number of register stages; legal range 1..16.
- DATA_W, 32: result width.
- ADDR_W, 5: destination register address width.
- OCC_W, $clog2(DEPTH+1): occupancy counter width. Derived; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  an entry is presented at stage 0.
- in_regwrite  in  1  the entry writes the register file.
- in_wreg  in  ADDR_W  destination register.
- in_result  in  DATA_W  result from the previous multiplier stage.
- in_zero  in  1  zero flag.
- in_overflow  in  1  overflow flag.
- stall  in  1  freeze all stages.
- flush  in  1  kill all in-flight entries.
- out_valid  out  1  the last stage holds a live entry.
- out_regwrite  out  1  equals last-stage valid AND regwrite.
- out_wreg  out  ADDR_W  destination register of the last stage.
- out_result  out  DATA_W  result of the last stage.
- out_zero, out_overflow  out  1 each  flags of the last stage.
- occupancy  out  OCC_W  number of valid stages.
- query_reg  in  ADDR_W  register number for the hazard query.
- query_hit  out  1  hazard-query result.

## Operation
- Each stage k holds: valid, regwrite, wreg, result, zero, overflow.
- Advance: on a clk edge with rst_n=1, stall=0 and flush=0:
  - stage 0 loads the in_* inputs; its valid bit loads in_valid.
  - stage k loads stage k-1, for k = 1..DEPTH-1.
  - Bubbles (valid=0) propagate like entries.
- Stall: with stall=1 and flush=0, every stage holds. The inputs are not sampled, so upstream must hold its entry.
- Flush: with flush=1, all valid bits and regwrite bits clear on the edge, regardless of stall. An entry presented in the same cycle is dropped. Data fields may keep stale values.
- Priority: rst_n=0, then flush, then stall, then advance.
- Outputs:
  - All out_* signals are driven directly from last-stage flops. out_regwrite is the AND of two flops.
  - Writeback commits when out_regwrite=1 and stall=0.
  - While stalled, the outputs hold steady and must not be recommitted.
- Occupancy:
  - Registered.
  - Advance: next = occupancy + in_valid − out_valid.
  - Stall: holds.
  - Flush: 0.
  - Must always equal the population count of the stage valid bits; the bench checks this as an assertion.
- Widths: occupancy never exceeds DEPTH, and arithmetic is OCC_W wide with no wrap. No arithmetic is performed on result; it is copied bit-exact.

## Timing
- Reset (rst_n=0 at an edge) clears every stage field to 0 and occupancy to 0.
  - Reset values: out_valid=0, out_regwrite=0, out_wreg=0, out_result=0, out_zero=0, out_overflow=0, occupancy=0, query_hit=0.
  - Reset mid-operation discards all entries in one cycle.
- Latency: an entry sampled at edge N appears on out_* after edge N+DEPTH−1, given no stall. DEPTH=1 behaves as a single register stage.
- Each stall cycle adds exactly one cycle of latency to every in-flight entry.
- Throughput: one entry per unstalled cycle; there is no backpressure other than stall.
- query_hit is combinational from the stage flops and query_reg, with no added latency.

## Configuration
- MULT_PIPE_HAZARD_EN defined: query_hit = OR over all stages k of (valid_k AND regwrite_k AND wreg_k == query_reg), gated with query_reg != 0.
  - Register 0 never hits.
  - The last stage is included.
  - Decode uses this to stall dependent instructions.
- Not defined: query_reg is ignored, query_hit is tied to 0, and no comparators are synthesised. The port list is unchanged.

## Test plan
- Reset then stream: with DEPTH=4, rst_n low for 2 cycles, then in_valid=1, wreg=5, result=0x0000_1234, regwrite=1 for one cycle.
  - Required: out_valid=1 with result 0x1234 and wreg 5 exactly 4 edges later.
  - Occupancy runs 1,1,1,1, then 0.
- Back-to-back: 6 consecutive entries with results 1..6.
  - Required: outputs 1..6 on consecutive cycles.
  - Occupancy peaks at 4 and returns to 0.
- Stall mid-flight: 2 entries in flight, then stall=1 for 3 cycles.
  - Required: all outputs and occupancy frozen.
  - Entries emerge 3 cycles later than unstalled, in order and uncorrupted.
- Flush with stall and input: 3 entries in flight, flush=1, stall=1, in_valid=1 in the same cycle.
  - Required: next cycle out_valid=0 and occupancy=0.
  - No later out_regwrite from any of the 4 entries.
- Hazard query (macro on): entry with wreg=7, regwrite=1 in stage 2, query_reg=7.
  - Required: query_hit=1. query_reg=0 or 8 gives 0.
  - Same entry with regwrite=0 gives 0.
  - With the macro off, query_hit=0 in all cases.
- DEPTH=1 build: an entry sampled at edge N appears on out_* after edge N, one edge later; in_valid=1 every cycle keeps occupancy at 1.

Source files
------------

// File: rtl/mult_pipe.sv
// mult_pipe: multiplier result pipeline for the exec stage.
// Carries a result and its side information through DEPTH register stages to writeback,
// with per-stage valid tracking, global stall, flush and a registered occupancy count.
// Optional hazard-query comparators are compiled in when MULT_PIPE_HAZARD_EN is defined;
// otherwise query_reg is ignored and query_hit is tied low.
module mult_pipe #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_regwrite,
   input  logic [ADDR_W-1:0] in_wreg,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_zero,
   input  logic              in_overflow,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic              out_regwrite,
   output logic [ADDR_W-1:0] out_wreg,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_overflow,
   output logic [OCC_W-1:0]  occupancy,
   input  logic [ADDR_W-1:0] query_reg,
   output logic              query_hit
);

   logic [DEPTH-1:0]             valid_q;
   logic [DEPTH-1:0]             regwrite_q;
   logic [DEPTH-1:0][ADDR_W-1:0] wreg_q;
   logic [DEPTH-1:0][DATA_W-1:0] result_q;
   logic [DEPTH-1:0]             zero_q;
   logic [DEPTH-1:0]             overflow_q;
   logic [OCC_W-1:0]             occ_q;
   logic [OCC_W-1:0]             occ_d;

   // Next occupancy on advance; subtract before add so the sum never exceeds DEPTH.
   always_comb begin
      occ_d = occ_q - OCC_W'(valid_q[DEPTH-1]) + OCC_W'(in_valid);
   end

   // Stage registers: reset, then flush, then stall, then advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= '0;
         regwrite_q <= '0;
         wreg_q     <= '0;
         result_q   <= '0;
         zero_q     <= '0;
         overflow_q <= '0;
         occ_q      <= '0;
      end else if (flush) begin
         // Data fields keep stale values; only liveness is killed.
         valid_q    <= '0;
         regwrite_q <= '0;
         occ_q      <= '0;
      end else if (!stall) begin
         valid_q[0]    <= in_valid;
         regwrite_q[0] <= in_regwrite;
         wreg_q[0]     <= in_wreg;
         result_q[0]   <= in_result;
         zero_q[0]     <= in_zero;
         overflow_q[0] <= in_overflow;
         for (int k = 1; k < DEPTH; k++) begin
            valid_q[k]    <= valid_q[k-1];
            regwrite_q[k] <= regwrite_q[k-1];
            wreg_q[k]     <= wreg_q[k-1];
            result_q[k]   <= result_q[k-1];
            zero_q[k]     <= zero_q[k-1];
            overflow_q[k] <= overflow_q[k-1];
         end
         occ_q <= occ_d;
      end
   end

   // Writeback view comes straight from last-stage flops.
   always_comb begin
      out_valid    = valid_q[DEPTH-1];
      out_regwrite = valid_q[DEPTH-1] & regwrite_q[DEPTH-1];
      out_wreg     = wreg_q[DEPTH-1];
      out_result   = result_q[DEPTH-1];
      out_zero     = zero_q[DEPTH-1];
      out_overflow = overflow_q[DEPTH-1];
      occupancy    = occ_q;
   end

`ifdef MULT_PIPE_HAZARD_EN
   logic any_hit;

   // Any live, writing stage (last stage included) targeting query_reg; r0 never hits.
   always_comb begin
      any_hit = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (valid_q[k] && regwrite_q[k] && (wreg_q[k] == query_reg)) begin
            any_hit = 1'b1;
         end
      end
      query_hit = any_hit && (query_reg != '0);
   end
`else
   logic unused_query;

   // Hazard query not built: port kept, result tied low.
   always_comb begin
      unused_query = ^query_reg;
      query_hit    = 1'b0;
   end
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed self-checking bench for mult_pipe (DEPTH=4 plus a DEPTH=1 instance).
// Hazard expectations follow MULT_PIPE_HAZARD_EN.
module tb_mult_pipe;

   localparam int unsigned DEPTH = 4;
`ifdef MULT_PIPE_HAZARD_EN
   localparam logic HAZ = 1'b1;
`else
   localparam logic HAZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_regwrite, in_zero, in_overflow;
   logic [4:0]  in_wreg;
   logic [31:0] in_result;
   logic        stall, flush;
   logic [4:0]  query_reg;

   logic        out_valid, out_regwrite, out_zero, out_overflow, query_hit;
   logic [4:0]  out_wreg;
   logic [31:0] out_result;
   logic [2:0]  occupancy;

   logic        d1_valid, d1_regwrite, d1_zero, d1_overflow, d1_hit;
   logic [4:0]  d1_wreg;
   logic [31:0] d1_result;
   logic [0:0]  d1_occ;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mult_pipe #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_regwrite(in_regwrite), .in_wreg(in_wreg),
      .in_result(in_result), .in_zero(in_zero), .in_overflow(in_overflow),
      .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_regwrite(out_regwrite), .out_wreg(out_wreg),
      .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow),
      .occupancy(occupancy), .query_reg(query_reg), .query_hit(query_hit)
   );

   mult_pipe #(.DEPTH(1), .DATA_W(32), .ADDR_W(5)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_regwrite(in_regwrite), .in_wreg(in_wreg),
      .in_result(in_result), .in_zero(in_zero), .in_overflow(in_overflow),
      .stall(stall), .flush(flush),
      .out_valid(d1_valid), .out_regwrite(d1_regwrite), .out_wreg(d1_wreg),
      .out_result(d1_result), .out_zero(d1_zero), .out_overflow(d1_overflow),
      .occupancy(d1_occ), .query_reg(query_reg), .query_hit(d1_hit)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] w,
                        input logic [31:0] r, input logic z, input logic o);
      in_valid    = v;
      in_regwrite = rw;
      in_wreg     = w;
      in_result   = r;
      in_zero     = z;
      in_overflow = o;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
   endtask

   // Occupancy must always equal the number of live stages.
   always @(negedge clk) begin
      if (chk_en) chk("occ_popcount", 64'(occupancy), 64'($countones(u_dut.valid_q)));
   end

   int          occ_tab[10] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0};
   logic        exp_v;
   logic [31:0] r;

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; query_reg = 5'd0;
      idle();
      step(); step();
      chk("rst_valid", out_valid, 0);
      chk("rst_regwrite", out_regwrite, 0);
      chk("rst_wreg", out_wreg, 0);
      chk("rst_result", out_result, 0);
      chk("rst_zero", out_zero, 0);
      chk("rst_overflow", out_overflow, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_hit", query_hit, 0);
      chk_en = 1'b1;
      rst_n  = 1'b1;

      // Single entry: visible after the 4th edge counting the sampling edge.
      drive(1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0);
      step();
      chk("one_occ0", occupancy, 1); chk("one_v0", out_valid, 0);
      idle();
      step(); chk("one_occ1", occupancy, 1); chk("one_v1", out_valid, 0);
      step(); chk("one_occ2", occupancy, 1); chk("one_v2", out_valid, 0);
      step();
      chk("one_v3", out_valid, 1);
      chk("one_result", out_result, 32'h1234);
      chk("one_wreg", out_wreg, 5);
      chk("one_rw", out_regwrite, 1);
      chk("one_occ3", occupancy, 1);
      step(); chk("one_v4", out_valid, 0); chk("one_occ4", occupancy, 0);

      // Back-to-back results 1..6.
      for (int j = 0; j < 10; j++) begin
         if (j < 6) begin
            r = 32'(j + 1);
            drive(1'b1, 1'b1, r[4:0], r, r[0], r[1]);
         end else begin
            idle();
         end
         step();
         exp_v = (j >= 3 && j <= 8);
         chk("b2b_valid", out_valid, exp_v);
         chk("b2b_occ", occupancy, occ_tab[j]);
         if (exp_v) begin
            r = 32'(j - 2);
            chk("b2b_result", out_result, r);
            chk("b2b_wreg", out_wreg, r[4:0]);
            chk("b2b_zero", out_zero, r[0]);
            chk("b2b_ovf", out_overflow, r[1]);
         end
      end

      // Stall with two entries in flight; junk presented while stalled is not sampled.
      drive(1'b1, 1'b1, 5'd10, 32'h0000_000A, 1'b0, 1'b0); step();
      drive(1'b1, 1'b1, 5'd11, 32'h0000_000B, 1'b0, 1'b0); step();
      chk("stl_occ_pre", occupancy, 2);
      stall = 1'b1;
      drive(1'b1, 1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b1);
      for (int j = 0; j < 3; j++) begin
         step();
         chk("stl_occ", occupancy, 2);
         chk("stl_valid", out_valid, 0);
      end
      stall = 1'b0;
      idle();
      step(); chk("stl_v_a0", out_valid, 0); chk("stl_occ_a0", occupancy, 2);
      step();
      chk("stl_v_a", out_valid, 1); chk("stl_res_a", out_result, 32'hA);
      chk("stl_wreg_a", out_wreg, 10); chk("stl_occ_a", occupancy, 2);
      stall = 1'b1;
      step();
      chk("stl_hold_res", out_result, 32'hA); chk("stl_hold_rw", out_regwrite, 1);
      chk("stl_hold_occ", occupancy, 2);
      stall = 1'b0;
      step();
      chk("stl_res_b", out_result, 32'hB); chk("stl_wreg_b", out_wreg, 11);
      chk("stl_occ_b", occupancy, 1);
      step(); chk("stl_v_end", out_valid, 0); chk("stl_occ_end", occupancy, 0);

      // Flush beats stall and drops the entry presented in the same cycle.
      for (int j = 1; j <= 3; j++) begin
         drive(1'b1, 1'b1, 5'(j), 32'(j + 16), 1'b0, 1'b0);
         step();
      end
      chk("fl_occ_pre", occupancy, 3); chk("fl_v_pre", out_valid, 0);
      flush = 1'b1; stall = 1'b1;
      drive(1'b1, 1'b1, 5'd4, 32'h14, 1'b0, 1'b0);
      step();
      chk("fl_valid", out_valid, 0); chk("fl_occ", occupancy, 0);
      chk("fl_rw", out_regwrite, 0);
      flush = 1'b0; stall = 1'b0;
      idle();
      for (int j = 0; j < 5; j++) begin
         step();
         chk("fl_rw_after", out_regwrite, 0);
         chk("fl_occ_after", occupancy, 0);
      end

      // Hazard query against an entry sitting in stage 2, then the last stage.
      drive(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0); step();
      idle(); step(); step();
      query_reg = 5'd7; #1; chk("hz_hit7", query_hit, HAZ);
      query_reg = 5'd0; #1; chk("hz_r0", query_hit, 0);
      query_reg = 5'd8; #1; chk("hz_r8", query_hit, 0);
      query_reg = 5'd7;
      step(); chk("hz_last", query_hit, HAZ); chk("hz_last_v", out_valid, 1);
      step(); chk("hz_gone", query_hit, 0);
      drive(1'b1, 1'b0, 5'd7, 32'h78, 1'b0, 1'b0); step();
      idle(); step(); step();
      chk("hz_norw", query_hit, 0);
      flush = 1'b1; step(); flush = 1'b0;
      query_reg = 5'd0;

      // Reset mid-operation discards everything in one cycle.
      drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0); step();
      rst_n = 1'b0; step();
      chk("mrst_occ", occupancy, 0); chk("mrst_valid", out_valid, 0);
      chk("mrst_result", out_result, 0);
      rst_n = 1'b1;
      idle(); step();

      // DEPTH=1 instance: one-edge latency, occupancy pinned at 1 under streaming.
      drive(1'b1, 1'b1, 5'd3, 32'h55, 1'b1, 1'b0); step();
      chk("d1_valid0", d1_valid, 1); chk("d1_res0", d1_result, 32'h55);
      chk("d1_wreg0", d1_wreg, 3); chk("d1_zero0", d1_zero, 1);
      chk("d1_occ0", d1_occ, 1);
      drive(1'b1, 1'b1, 5'd4, 32'h66, 1'b0, 1'b1); step();
      chk("d1_res1", d1_result, 32'h66); chk("d1_ovf1", d1_overflow, 1);
      chk("d1_occ1", d1_occ, 1); chk("d1_rw1", d1_regwrite, 1);
      idle(); step();
      chk("d1_valid2", d1_valid, 0); chk("d1_occ2", d1_occ, 0);
      chk("d1_rw2", d1_regwrite, 0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
